mole_spawn_timer: RTL

- Upstream neighbour of whac_a_mole_fsm. Supplies `led_number`, the one-hot position of the active mole, and `timeout`, the hit-window-alive flag, and the FSM consumes both.
- Uses a free-running 16-bit LFSR to pick a pseudo-random mole position among NUM_MOLES LEDs. A position never repeats back-to-back.
- Runs a level-dependent countdown for the hit window.
- Takes `ready_for_mole`, `timeout_start` and `level_number` from the FSM.

---
 rtl/whac_pkg.sv | 16 +
 rtl/lfsr16.sv | 34 +++
 rtl/mole_spawn_timer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/whac_pkg.sv
// Shared types and constants for the whack-a-mole spawn/timeout logic.
package whac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } spawn_state_t;

    typedef logic [1:0] level_t;

    localparam int          NUM_MOLES_DEF     = 18;
    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right-shifting form) with a seed that can never be 0.
module lfsr16
    import whac_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED,
    parameter logic [15:0] MASK = LFSR_MASK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] value
);

    // An all-zero seed would lock the register at 0 forever.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] value_n;

    always_comb begin
        value_n = value;
        if (en) begin
            value_n = {1'b0, value[15:1]} ^ (value[0] ? MASK : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED_EFF;
        end else begin
            value <= value_n;
        end
    end

endmodule

// File: rtl/mole_spawn_timer.sv
// Picks a non-repeating pseudo-random mole LED and times the level-dependent hit window.
module mole_spawn_timer
    import whac_pkg::*;
#(
    parameter int          CLK_HZ       = 50_000_000,
    parameter int          TICK_HZ      = 1000,
    parameter int          NUM_MOLES    = NUM_MOLES_DEF,
    parameter int          LEVEL1_TICKS = 1500,
    parameter int          LEVEL2_TICKS = 1000,
    parameter int          LEVEL3_TICKS = 600,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ready_for_mole,
    input  logic                 timeout_start,
    input  level_t               level_number,
    output logic [NUM_MOLES-1:0] led_number,
    output logic                 timeout,
    output logic [15:0]          window_ticks_left,
    output spawn_state_t         state
);

    localparam int                 DIV     = CLK_HZ / TICK_HZ;
    localparam int                 PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [5:0]         IDX_N   = 6'(NUM_MOLES);
    localparam logic [NUM_MOLES-1:0] ONE   = NUM_MOLES'(1);

    logic [15:0]          lfsr_value;
    logic                 unused_lfsr_bits;
    logic [PRE_W-1:0]     prescaler, prescaler_n;
    logic [5:0]           prev_idx, prev_idx_n;
    level_t               level_q, level_n;
    spawn_state_t         state_n;
    logic [NUM_MOLES-1:0] led_n;
    logic                 timeout_n;
    logic [15:0]          ticks_n;
    logic [5:0]           raw_ext, fold_idx, sel_idx;
    logic [15:0]          window_len;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .MASK (LFSR_MASK)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .value (lfsr_value)
    );

    assign unused_lfsr_bits = ^lfsr_value[15:5];

    // Single subtract is enough because the 5-bit raw value is below 2*NUM_MOLES.
    always_comb begin
        raw_ext  = {1'b0, lfsr_value[4:0]};
        fold_idx = (raw_ext >= IDX_N) ? raw_ext - IDX_N : raw_ext;
        sel_idx  = fold_idx;
        if (fold_idx == prev_idx) begin
            sel_idx = (fold_idx + 6'd1 == IDX_N) ? 6'd0 : fold_idx + 6'd1;
        end
    end

    always_comb begin
        case (level_q)
            2'd2:    window_len = 16'(LEVEL2_TICKS);
            2'd3:    window_len = 16'(LEVEL3_TICKS);
            default: window_len = 16'(LEVEL1_TICKS);
        endcase
        if (window_len == 16'd0) begin
            window_len = 16'd1;
        end
    end

    always_comb begin
        state_n     = state;
        led_n       = led_number;
        timeout_n   = timeout;
        ticks_n     = window_ticks_left;
        prescaler_n = prescaler;
        prev_idx_n  = prev_idx;
        level_n     = (level_number != 2'd0) ? level_number : level_q;

        if (ready_for_mole) begin
            led_n       = ONE << sel_idx;
            prev_idx_n  = sel_idx;
            timeout_n   = 1'b1;
            ticks_n     = window_len;
            prescaler_n = '0;
            state_n     = ARMED;
        end else begin
            case (state)
                IDLE: begin
                end
                ARMED: begin
                    if (!timeout_start) begin
                        led_n     = '0;
                        timeout_n = 1'b0;
                        ticks_n   = 16'd0;
                        state_n   = IDLE;
                    end else if (prescaler == PRE_MAX) begin
                        prescaler_n = '0;
                        if (window_ticks_left > 16'd1) begin
                            ticks_n = window_ticks_left - 16'd1;
                        end else begin
                            ticks_n   = 16'd0;
                            led_n     = '0;
                            timeout_n = 1'b0;
                            state_n   = EXPIRED;
                        end
                    end else begin
                        prescaler_n = prescaler + PRE_W'(1);
                    end
                end
                EXPIRED: begin
                    if (!timeout_start) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    led_n     = '0;
                    timeout_n = 1'b0;
                    ticks_n   = 16'd0;
                    state_n   = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            led_number        <= '0;
            timeout           <= 1'b0;
            window_ticks_left <= 16'd0;
            prescaler         <= '0;
            prev_idx          <= IDX_N;
            level_q           <= 2'd1;
        end else begin
            state             <= state_n;
            led_number        <= led_n;
            timeout           <= timeout_n;
            window_ticks_left <= ticks_n;
            prescaler         <= prescaler_n;
            prev_idx          <= prev_idx_n;
            level_q           <= level_n;
        end
    end

endmodule
